// File: rtl/bgr_stream_serializer.sv
// Rounds and saturates filtered channel sums to bytes and
// serializes each pixel as B, G, R with frame position tracking.
module bgr_stream_serializer #(
  parameter int ROWS = 192,
  parameter int COLS = 192,
  parameter int IN_W = 16,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [IN_W-1:0] pix_b,
  input  logic [IN_W-1:0] pix_g,
  input  logic [IN_W-1:0] pix_r,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic [7:0]      byte_data,
  output logic            byte_last,
  output logic            frame_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND_B = 2'd1;
  localparam logic [1:0] SEND_G = 2'd2;
  localparam logic [1:0] SEND_R = 2'd3;

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (FRAC - 1);
  localparam logic [IN_W:0] MAXQ = (IN_W+1)'(255);
  localparam logic [CW-1:0] COL_END = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);

  // Round half up, then clamp anything above 255.
  function automatic logic [7:0] conv(input logic [IN_W-1:0] x);
    logic [IN_W:0] t;
    logic [IN_W:0] q;
    t = {1'b0, x} + HALF;
    q = t >> FRAC;
    conv = (q > MAXQ) ? 8'hFF : q[7:0];
  endfunction

  logic [1:0]    state_q, state_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    g_q, g_d;
  logic [7:0]    r_q, r_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_done_q, frame_done_d;

  logic pix_xfer;
  logic byte_xfer;
  logic at_end;

  always_comb begin
    pix_ready  = (state_q == IDLE) ||
                 ((state_q == SEND_R) && byte_ready);
    byte_valid = (state_q != IDLE);
    pix_xfer   = pix_valid && pix_ready;
    byte_xfer  = byte_valid && byte_ready;
    at_end     = (row_q == ROW_END) && (col_q == COL_END);
    byte_last  = (state_q == SEND_R) && at_end;
    frame_done = frame_done_q;
    unique case (state_q)
      SEND_B:  byte_data = b_q;
      SEND_G:  byte_data = g_q;
      SEND_R:  byte_data = r_q;
      default: byte_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pix_xfer) state_d = SEND_B;
      SEND_B:  if (byte_xfer) state_d = SEND_G;
      SEND_G:  if (byte_xfer) state_d = SEND_R;
      default: if (byte_xfer) state_d = pix_xfer ? SEND_B : IDLE;
    endcase
  end

  always_comb begin
    b_d = b_q;
    g_d = g_q;
    r_d = r_q;
    if (pix_xfer) begin
      b_d = conv(pix_b);
      g_d = conv(pix_g);
      r_d = conv(pix_r);
    end
  end

  // Position moves only once the R byte of a pixel leaves.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (byte_xfer && (state_q == SEND_R)) begin
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    frame_done_d = byte_xfer && byte_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      b_q          <= '0;
      g_q          <= '0;
      r_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      g_q          <= g_d;
      r_q          <= r_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bgr_stream_serializer.sv
// Randomized bench for bgr_stream_serializer against a byte-queue
// model of the B,G,R stream with frame position by byte count.
module tb_bgr_stream_serializer;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int IN_W = 16;
  localparam int FRAC = 8;
  localparam int NPIX = ROWS * COLS;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_b;
  logic [15:0] pix_g;
  logic [15:0] pix_r;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        frame_done;

  int n_cmp;
  int n_bad;

  bgr_stream_serializer #(
    .ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_b(pix_b), .pix_g(pix_g), .pix_r(pix_r),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_last(byte_last),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: bytes owed downstream, bytes sent since reset.
  logic [7:0] exp_q[$];
  int         nbytes;
  logic       fd_pend;

  logic       obs_pr, obs_bv, obs_bl, obs_fd;
  logic [7:0] obs_bd;
  logic       exp_pr, exp_bv, exp_bl, exp_fd;
  logic [7:0] exp_bd;
  logic       did_byte;

  function automatic logic [7:0] ref_conv(input logic [15:0] x);
    int v;
    v = (int'(x) + (1 << (FRAC - 1))) / (1 << FRAC);
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    nbytes  = 0;
    fd_pend = 1'b0;
  endtask

  task automatic cycle(input logic pv, input logic [15:0] b,
                       input logic [15:0] g, input logic [15:0] r,
                       input logic br);
    @(negedge clk);
    pix_valid  = pv;
    pix_b      = b;
    pix_g      = g;
    pix_r      = r;
    byte_ready = br;
    #1;
    obs_pr = pix_ready;
    obs_bv = byte_valid;
    obs_bd = byte_data;
    obs_bl = byte_last;
    obs_fd = frame_done;
    exp_bv = (exp_q.size() != 0);
    exp_pr = (exp_q.size() == 0) || (exp_q.size() == 1 && br);
    exp_bd = exp_bv ? exp_q[0] : 8'h00;
    exp_bl = exp_bv && ((nbytes % (3 * NPIX)) == 3 * NPIX - 1);
    exp_fd = fd_pend;
    @(posedge clk);
    did_byte = exp_bv && br;
    fd_pend  = did_byte && exp_bl;
    if (did_byte) begin
      void'(exp_q.pop_front());
      nbytes++;
    end
    if (exp_pr && pv) begin
      exp_q.push_back(ref_conv(b));
      exp_q.push_back(ref_conv(g));
      exp_q.push_back(ref_conv(r));
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pix_valid  = 1'b0;
    byte_ready = 1'b0;
    pix_b = '0; pix_g = '0; pix_r = '0;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_bv got %b want 0", byte_valid);
    end
    n_cmp++;
    if (pix_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_pr got %b want 1", pix_ready);
    end
    n_cmp++;
    if (byte_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_bd got %h want 00", byte_data);
    end
    n_cmp++;
    if (byte_last !== 1'b0 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b%b want 00", byte_last, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pixel(input string nm, input logic [15:0] b,
                            input logic [15:0] g, input logic [15:0] r,
                            input logic [7:0] eb, input logic [7:0] eg,
                            input logic [7:0] er);
    logic [7:0] want[3];
    want[0] = eb; want[1] = eg; want[2] = er;
    cycle(1'b1, b, g, r, 1'b1);
    n_cmp++;
    if (obs_pr !== 1'b1) begin
      n_bad++; $display("FAIL %s_accept pr got %b want 1", nm, obs_pr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      n_cmp++;
      if (obs_bv !== 1'b1 || obs_bd !== want[i]) begin
        n_bad++;
        $display("FAIL %s_byte%0d got %b/%h want 1/%h",
                 nm, i, obs_bv, obs_bd, want[i]);
      end
      n_cmp++;
      if (obs_pr !== (i == 2)) begin
        n_bad++;
        $display("FAIL %s_pr%0d got %b want %b", nm, i, obs_pr, i == 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] b, g, r;
    b = 16'($urandom); g = 16'($urandom); r = 16'($urandom);
    cycle(1'b1, b, g, r, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
      n_cmp++;
      if (obs_bv !== 1'b1 || obs_bd !== ref_conv(g) || obs_pr !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d got v%b d%h pr%b want v1 d%h pr0",
                 i, obs_bv, obs_bd, obs_pr, ref_conv(g));
      end
    end
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    n_cmp++;
    if (obs_bd !== ref_conv(g)) begin
      n_bad++; $display("FAIL stall_rel got %h want %h", obs_bd, ref_conv(g));
    end
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    n_cmp++;
    if (obs_bv !== 1'b1 || obs_bd !== ref_conv(r)) begin
      n_bad++;
      $display("FAIL stall_r got %b/%h want 1/%h", obs_bv, obs_bd, ref_conv(r));
    end
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    n_cmp++;
    if (obs_bv !== 1'b0) begin
      n_bad++; $display("FAIL stall_idle bv got %b want 0", obs_bv);
    end
  endtask

  task automatic test_frame_wrap();
    int acc, cyc, first_x, last_x, nx, last_idx, n_last, n_fd, fd_cyc;
    acc = 0; cyc = 0; first_x = -1; last_x = -1; nx = 0;
    last_idx = -1; n_last = 0; n_fd = 0; fd_cyc = -1;
    while ((acc < 7 || exp_q.size() != 0 || fd_pend) && cyc < 60) begin
      cycle(acc < 7, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      if (exp_pr && acc < 7) acc++;
      n_cmp++;
      if (obs_pr !== exp_pr || obs_bv !== exp_bv ||
          (exp_bv && obs_bd !== exp_bd) || obs_bl !== exp_bl ||
          obs_fd !== exp_fd) begin
        n_bad++;
        $display("FAIL wrap_c%0d got pr%b v%b d%h l%b f%b want pr%b v%b d%h l%b f%b",
                 cyc, obs_pr, obs_bv, obs_bd, obs_bl, obs_fd,
                 exp_pr, exp_bv, exp_bd, exp_bl, exp_fd);
      end
      if (obs_bv) begin
        nx++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (obs_bl) begin n_last++; last_idx = nx; end
      end
      if (obs_fd) begin n_fd++; fd_cyc = cyc; end
      cyc++;
    end
    n_cmp++;
    if (nx != 21 || last_x - first_x != 20) begin
      n_bad++;
      $display("FAIL wrap_count got %0d bytes span %0d want 21 span 20",
               nx, last_x - first_x);
    end
    n_cmp++;
    if (n_last != 1 || last_idx != 18) begin
      n_bad++;
      $display("FAIL wrap_last got n%0d at %0d want n1 at 18", n_last, last_idx);
    end
    n_cmp++;
    if (n_fd != 1 || fd_cyc != first_x + 18) begin
      n_bad++;
      $display("FAIL wrap_fd got n%0d at %0d want n1 at %0d",
               n_fd, fd_cyc, first_x + 18);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n_last, nx;
    cycle(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    cycle(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    cycle(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    cycle(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    @(negedge clk);
    #2;
    n_cmp++;
    if (byte_valid !== 1'b1 || exp_q.size() != 2) begin
      n_bad++;
      $display("FAIL rmid_pre got v%b q%0d want v1 q2", byte_valid, exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (byte_valid !== 1'b0 || pix_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_drop got v%b pr%b want v0 pr1", byte_valid, pix_ready);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; n_last = 0; nx = 0;
    while ((nx < 3 * NPIX || exp_q.size() != 0) && cyc < 80) begin
      cycle(nx < 3 * NPIX - 3, 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom));
      n_cmp++;
      if (obs_pr !== exp_pr || obs_bv !== exp_bv ||
          (exp_bv && obs_bd !== exp_bd) || obs_bl !== exp_bl ||
          obs_fd !== exp_fd) begin
        n_bad++;
        $display("FAIL rmid_c%0d got pr%b v%b d%h l%b f%b want pr%b v%b d%h l%b f%b",
                 cyc, obs_pr, obs_bv, obs_bd, obs_bl, obs_fd,
                 exp_pr, exp_bv, exp_bd, exp_bl, exp_fd);
      end
      if (did_byte) begin
        nx++;
        if (obs_bl) n_last++;
      end
      cyc++;
    end
    n_cmp++;
    if (nx != 3 * NPIX || n_last != 1) begin
      n_bad++;
      $display("FAIL rmid_frame got %0d bytes %0d last want %0d bytes 1 last",
               nx, n_last, 3 * NPIX);
    end
  endtask

  task automatic test_random_gaps();
    int cyc;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom));
      n_cmp++;
      if (obs_pr !== exp_pr || obs_bv !== exp_bv ||
          (exp_bv && obs_bd !== exp_bd) || obs_bl !== exp_bl ||
          obs_fd !== exp_fd) begin
        n_bad++;
        $display("FAIL rand_c%0d got pr%b v%b d%h l%b f%b want pr%b v%b d%h l%b f%b",
                 i, obs_pr, obs_bv, obs_bd, obs_bl, obs_fd,
                 exp_pr, exp_bv, exp_bd, exp_bl, exp_fd);
      end
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
      n_cmp++;
      if (obs_bv !== 1'b1 || obs_bd !== exp_bd || obs_bl !== exp_bl) begin
        n_bad++;
        $display("FAIL drain_c%0d got v%b d%h l%b want v1 d%h l%b",
                 cyc, obs_bv, obs_bd, obs_bl, exp_bd, exp_bl);
      end
      cyc++;
    end
    cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    n_cmp++;
    if (obs_bv !== 1'b0) begin
      n_bad++; $display("FAIL drain_end bv got %b want 0", obs_bv);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pixel("round", 16'h7F80, 16'h7F7F, 16'h0000, 8'h80, 8'h7F, 8'h00);
    test_pixel("sat", 16'hFF80, 16'hFFFF, 16'h00FF, 8'hFF, 8'hFF, 8'h01);
    test_backpressure();
    test_reset();
    test_frame_wrap();
    test_reset_mid();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
